rf_write_scheduler: RTL and testbench
=====================================

# rf_write_scheduler

Write-port scheduler and load scoreboard for the 16x32 ARM register file. It shares the file's single write port between the in-order pipeline writeback and late-returning SRAM load data. It tracks registers with outstanding loads and raises a hazard stall to the ID stage. It sits between the WB stage, the SRAM controller, and RegisterFile (negedge-write, combinational read).

## Interface
Parameters:
- LD_DEPTH, 4, max outstanding loads (tag queue depth)
- RET_DEPTH, 2, load-return buffer depth

Ports:
- clk  in  1  system clock, posedge
- rst  in  1  reset, asynchronous, active-high
- wb_en  in  1  pipeline writeback valid; no backpressure
- wb_dest  in  4  writeback register
- wb_value  in  32  writeback data
- ld_issue  in  1  load issued to SRAM this cycle
- ld_issue_dest  in  4  load destination register
- ld_issue_ready  out  1  tag queue can accept an issue
- ld_valid  in  1  load data returning (in issue order)
- ld_data  in  32  returned data
- ld_ready  out  1  return buffer can accept
- id_src1, id_src2, id_dest  in  4 each  ID-stage operands
- id_use1, id_use2, id_wb  in  1 each  operand/dest actually used
- hazard_stall  out  1  ID must stall
- rf_we  out  1  to RegisterFile writeBackEn
- rf_dest  out  4  to RegisterFile Dest_wb
- rf_value  out  32  to RegisterFile Result_WB
- err  out  1  sticky protocol error

## Operation
- Tag queue (LD_DEPTH): push ld_issue_dest on ld_issue && ld_issue_ready. ld_issue_ready = count < LD_DEPTH; a same-cycle pop does not free space.
- Return: on ld_valid && ld_ready, pop tag queue head and push {tag, ld_data} into return buffer. ld_ready = return buffer not full and tag queue not empty.
- ld_valid with tag queue empty: data dropped, err set, held until rst.
- Write port: wb_en has absolute priority (rf_* = wb fields). Otherwise, if the return buffer is non-empty, its head drives rf_* and pops. rf_we = wb_en | buffer non-empty.
- Scoreboard: per-register pending counter, width clog2(LD_DEPTH+1). Increment on accepted issue. Decrement when a load entry is written to the RF. Simultaneous increment and decrement of the same register leaves it unchanged.
- hazard_stall = (id_use1 & busy[id_src1]) | (id_use2 & busy[id_src2]) | (id_wb & busy[id_dest]) | (ld_issue & !ld_issue_ready); busy = counter != 0. The id_dest term prevents WAW reordering.

## Timing
- Reset (async): queues empty, counters 0, err 0. While rst is high, rf_we = 0, ld_ready = 0, ld_issue_ready = 0, hazard_stall = 0, rf_dest = 0, rf_value = 0.
- rf_* is combinational from wb inputs or buffer head, valid in the same cycle; RegisterFile captures it at the following negedge.
- Load latency: data accepted at edge N reaches rf_* in cycle N+1 at the earliest. Each cycle with wb_en = 1 adds one cycle.
- Busy clears at the posedge after the RF write cycle of the load, so a dependent ID instruction stalls through the write cycle and proceeds the next cycle.
- Return buffer full: ld_ready = 0; the SRAM controller holds ld_valid/ld_data.
- rst mid-operation: all pending loads are discarded; a late ld_valid after reset sets err.

## Structure
- Package arm_rf_pkg holds REG_ADDR_W = 4, WORD_W = 32, NUM_REGS = 16, and typedef rf_wr_t {dest, data}.
- Sub-module rf_sync_fifo (parameterized width/depth, push/pop/full/empty/count, async rst) is instantiated twice: the tag queue (4-bit) and the return buffer (rf_wr_t).
- Scoreboard counters and the write mux stay in the top module.

## Test plan
- wb_en=1, wb_dest=3, wb_value=0xA5 with no loads -> rf_we=1, rf_dest=3, rf_value=0xA5 same cycle; hazard_stall=0.
- Issue load to R5; ID id_src1=5, id_use1=1 -> stall=1. Return 0x1234 with wb idle -> rf_* = {5, 0x1234} next cycle; stall drops the cycle after.
- Load returns to R2 while wb_en=1 for 3 consecutive cycles -> R2 written in the 4th cycle; wb writes never delayed.
- Four issues fill the tag queue -> ld_issue_ready=0 and hazard_stall=1 on a 5th ld_issue. Two returns with wb_en held high -> ld_ready=0 after two accepts.
- Two loads to R7 back-to-back -> busy until second write; counter reaches 2 then 0. Same-cycle issue to R7 with retirement of an R7 load -> counter unchanged.
- ld_valid with empty tag queue -> err=1 and stays 1. Assert rst mid-operation with 3 loads pending -> all outputs 0, busy cleared, err cleared.

Source files
------------

// File: rtl/arm_rf_pkg.sv
// Shared widths and the register-file write record used by the write scheduler.
package arm_rf_pkg;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [WORD_W-1:0]     data;
  } rf_wr_t;
endpackage

// File: rtl/rf_sync_fifo.sv
// Single-clock FIFO with async reset; push when full and pop when empty are ignored.
module rf_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the register-file write port between pipeline writeback and returning
// SRAM loads, and stalls ID on registers with loads still in flight.
module rf_write_scheduler
  import arm_rf_pkg::*;
#(
  parameter int unsigned LD_DEPTH  = 4,
  parameter int unsigned RET_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [WORD_W-1:0]     wb_value,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_dest,
  output logic                  ld_issue_ready,
  input  logic                  ld_valid,
  input  logic [WORD_W-1:0]     ld_data,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic                  id_wb,
  output logic                  hazard_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_dest,
  output logic [WORD_W-1:0]     rf_value,
  output logic                  err
);
  localparam int unsigned SB_W    = $clog2(LD_DEPTH+1);
  localparam int unsigned TAG_CW  = $clog2(LD_DEPTH+1);
  localparam int unsigned RET_CW  = $clog2(RET_DEPTH+1);

  logic [REG_ADDR_W-1:0] tag_head;
  logic                  tag_full, tag_empty;
  logic [TAG_CW-1:0]     tag_count;
  rf_wr_t                ret_head, ret_din;
  logic                  ret_full, ret_empty;
  logic [RET_CW-1:0]     ret_count;
  logic                  issue_acc, ret_push, ret_pop;
  logic [SB_W-1:0]       pending [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  unused_ok;

  assign unused_ok = ^{tag_full, ret_count};

  assign ld_issue_ready = !rst && (tag_count < TAG_CW'(LD_DEPTH));
  assign ld_ready       = !rst && !ret_full && !tag_empty;
  assign issue_acc      = ld_issue && ld_issue_ready;
  assign ret_push       = ld_valid && ld_ready;
  assign ret_din        = '{dest: tag_head, data: ld_data};

  rf_sync_fifo #(.WIDTH(REG_ADDR_W), .DEPTH(LD_DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_acc),
    .din   (ld_issue_dest),
    .pop   (ret_push),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  rf_sync_fifo #(.WIDTH($bits(rf_wr_t)), .DEPTH(RET_DEPTH)) u_ret_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_push),
    .din   (ret_din),
    .pop   (ret_pop),
    .dout  (ret_head),
    .full  (ret_full),
    .empty (ret_empty),
    .count (ret_count)
  );

  // Writeback always wins; a buffered load only drains in a cycle wb leaves idle.
  always_comb begin
    rf_we    = 1'b0;
    rf_dest  = '0;
    rf_value = '0;
    ret_pop  = 1'b0;
    if (!rst) begin
      if (wb_en) begin
        rf_we    = 1'b1;
        rf_dest  = wb_dest;
        rf_value = wb_value;
      end else if (!ret_empty) begin
        rf_we    = 1'b1;
        rf_dest  = ret_head.dest;
        rf_value = ret_head.data;
        ret_pop  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) pending[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (issue_acc && ld_issue_dest == REG_ADDR_W'(i) &&
            !(ret_pop && ret_head.dest == REG_ADDR_W'(i)))
          pending[i] <= pending[i] + 1'b1;
        else if (ret_pop && ret_head.dest == REG_ADDR_W'(i) &&
                 !(issue_acc && ld_issue_dest == REG_ADDR_W'(i)))
          pending[i] <= pending[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) busy[i] = (pending[i] != '0);
  end

  assign hazard_stall = !rst && ((id_use1 && busy[id_src1]) ||
                                 (id_use2 && busy[id_src2]) ||
                                 (id_wb   && busy[id_dest]) ||
                                 (ld_issue && !ld_issue_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   err <= 1'b0;
    else if (ld_valid && tag_empty) err <= 1'b1;
  end
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Randomized plus directed bench for rf_write_scheduler against a queue-based model.
module tb_rf_write_scheduler;
  import arm_rf_pkg::*;

  localparam int unsigned LD = 4;
  localparam int unsigned RB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0, ld_issue = 1'b0, ld_valid = 1'b0;
  logic [3:0]  wb_dest = '0, ld_issue_dest = '0, id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic [31:0] wb_value = '0, ld_data = '0;
  logic        id_use1 = 1'b0, id_use2 = 1'b0, id_wb = 1'b0;
  logic        ld_issue_ready, ld_ready, hazard_stall, rf_we, err;
  logic [3:0]  rf_dest;
  logic [31:0] rf_value;

  rf_write_scheduler #(.LD_DEPTH(LD), .RET_DEPTH(RB)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest), .ld_issue_ready(ld_issue_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_use1(id_use1), .id_use2(id_use2), .id_wb(id_wb),
    .hazard_stall(hazard_stall), .rf_we(rf_we), .rf_dest(rf_dest),
    .rf_value(rf_value), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0, total = 0;

  // Model: loads waiting for data, loads waiting for the write port, sticky error.
  logic [3:0] tagq [$];
  rf_wr_t     retq [$];
  logic       m_err = 1'b0;
  logic       hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic m_busy(input logic [3:0] r);
    int unsigned n = 0;
    foreach (tagq[i]) if (tagq[i] == r) n++;
    foreach (retq[i]) if (retq[i].dest == r) n++;
    return n != 0;
  endfunction

  task automatic model_check();
    logic ir, lr, we, st;
    ir = tagq.size() < LD;
    lr = (retq.size() < RB) && (tagq.size() > 0);
    we = wb_en || (retq.size() > 0);
    st = (id_use1 && m_busy(id_src1)) || (id_use2 && m_busy(id_src2)) ||
         (id_wb && m_busy(id_dest)) || (ld_issue && !ir);
    chk("ld_issue_ready", ld_issue_ready, ir);
    chk("ld_ready", ld_ready, lr);
    chk("rf_we", rf_we, we);
    chk("hazard_stall", hazard_stall, st);
    chk("err", err, m_err);
    if (we) begin
      chk("rf_dest", rf_dest, wb_en ? wb_dest : retq[0].dest);
      chk("rf_value", rf_value, wb_en ? wb_value : retq[0].data);
    end
  endtask

  task automatic model_update();
    logic ir, lr, acc;
    rf_wr_t e;
    ir  = tagq.size() < LD;
    lr  = (retq.size() < RB) && (tagq.size() > 0);
    acc = ld_valid && lr;
    if (ld_valid && tagq.size() == 0) m_err = 1'b1;
    if (!wb_en && retq.size() > 0) retq.delete(0);
    if (acc) begin
      e.dest = tagq[0];
      e.data = ld_data;
      tagq.delete(0);
      retq.push_back(e);
    end
    if (ld_issue && ir) tagq.push_back(ld_issue_dest);
    hold = ld_valid && !acc;
  endtask

  task automatic idle_inputs();
    wb_en = 0; ld_issue = 0; ld_valid = 0;
    id_use1 = 0; id_use2 = 0; id_wb = 0;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wb_en = 1; wb_dest = 4'hF; wb_value = 32'hDEAD_BEEF;
    ld_issue = 1; ld_valid = 1; id_use1 = 1; id_src1 = 4'd1; id_wb = 1; id_dest = 4'd2;
    #1;
    chk("rst rf_we", rf_we, 0);
    chk("rst ld_ready", ld_ready, 0);
    chk("rst ld_issue_ready", ld_issue_ready, 0);
    chk("rst hazard_stall", hazard_stall, 0);
    chk("rst rf_dest", rf_dest, 0);
    chk("rst rf_value", rf_value, 0);
    chk("rst err", err, 0);
    tagq.delete(); retq.delete(); m_err = 1'b0; hold = 1'b0;
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 30 && (tagq.size() > 0 || retq.size() > 0); c++) begin
      begin_cycle();
      ld_valid = tagq.size() > 0;
      ld_data  = 32'h0000_D000 + 32'(c);
      settle();
      end_cycle();
    end
    chk("drain done", tagq.size() + retq.size(), 0);
  endtask

  initial begin
    do_reset();

    // Plain writeback, no loads.
    begin_cycle(); wb_en = 1; wb_dest = 4'd3; wb_value = 32'hA5; settle();
    chk("wb rf_we", rf_we, 1); chk("wb rf_dest", rf_dest, 3);
    chk("wb rf_value", rf_value, 32'hA5); chk("wb stall", hazard_stall, 0);
    end_cycle();

    // Load to R5, dependent ID operand, return with wb idle.
    begin_cycle(); ld_issue = 1; ld_issue_dest = 4'd5; settle(); end_cycle();
    begin_cycle(); id_use1 = 1; id_src1 = 4'd5; ld_valid = 1; ld_data = 32'h1234; settle();
    chk("r5 stall pend", hazard_stall, 1); chk("r5 ld_ready", ld_ready, 1); end_cycle();
    begin_cycle(); id_use1 = 1; id_src1 = 4'd5; settle();
    chk("r5 rf_we", rf_we, 1); chk("r5 rf_dest", rf_dest, 5);
    chk("r5 rf_value", rf_value, 32'h1234); chk("r5 stall wr", hazard_stall, 1); end_cycle();
    begin_cycle(); id_use1 = 1; id_src1 = 4'd5; settle();
    chk("r5 stall clear", hazard_stall, 0); chk("r5 idle we", rf_we, 0); end_cycle();

    // Load to R2 returns under three cycles of writeback.
    begin_cycle(); ld_issue = 1; ld_issue_dest = 4'd2; settle(); end_cycle();
    for (int k = 0; k < 3; k++) begin
      begin_cycle(); wb_en = 1; wb_dest = 4'd9; wb_value = 32'(100 + k);
      ld_valid = (k == 0); ld_data = 32'h2222; settle();
      chk("r2 wb first", rf_dest, 9); end_cycle();
    end
    begin_cycle(); settle();
    chk("r2 4th we", rf_we, 1); chk("r2 4th dest", rf_dest, 2);
    chk("r2 4th value", rf_value, 32'h2222); end_cycle();

    // Fill tag queue, then return buffer with wb held high.
    for (int k = 1; k <= 4; k++) begin
      begin_cycle(); ld_issue = 1; ld_issue_dest = 4'(k); settle(); end_cycle();
    end
    begin_cycle(); ld_issue = 1; ld_issue_dest = 4'd6; settle();
    chk("full issue_ready", ld_issue_ready, 0); chk("full stall", hazard_stall, 1); end_cycle();
    for (int k = 0; k < 3; k++) begin
      begin_cycle(); wb_en = 1; wb_dest = 4'd0; ld_valid = 1; ld_data = 32'(k); settle();
      chk("retbuf ld_ready", ld_ready, (k < 2) ? 1 : 0); end_cycle();
    end
    drain();

    // Two loads to R7, then an R7 issue coinciding with an R7 retirement.
    begin_cycle(); ld_issue = 1; ld_issue_dest = 4'd7; settle(); end_cycle();
    begin_cycle(); ld_issue = 1; ld_issue_dest = 4'd7; id_wb = 1; id_dest = 4'd7; settle();
    chk("r7 stall", hazard_stall, 1); end_cycle();
    begin_cycle(); ld_valid = 1; ld_data = 32'h71; settle(); end_cycle();
    begin_cycle(); ld_valid = 1; ld_data = 32'h72; id_wb = 1; id_dest = 4'd7; settle();
    chk("r7 first wr", rf_value, 32'h71); chk("r7 busy2", hazard_stall, 1); end_cycle();
    begin_cycle(); ld_issue = 1; ld_issue_dest = 4'd7; settle();
    chk("r7 second wr", rf_value, 32'h72); end_cycle();
    begin_cycle(); id_wb = 1; id_dest = 4'd7; ld_valid = 1; ld_data = 32'h73; settle();
    chk("r7 still busy", hazard_stall, 1); end_cycle();
    begin_cycle(); id_wb = 1; id_dest = 4'd7; settle();
    chk("r7 third wr", rf_value, 32'h73); chk("r7 busy wr", hazard_stall, 1); end_cycle();
    begin_cycle(); id_wb = 1; id_dest = 4'd7; settle();
    chk("r7 free", hazard_stall, 0); end_cycle();

    // Return with nothing outstanding.
    begin_cycle(); ld_valid = 1; ld_data = 32'hBAD; settle();
    chk("err ld_ready", ld_ready, 0); end_cycle();
    for (int k = 0; k < 3; k++) begin
      begin_cycle(); settle(); chk("err sticky", err, 1); end_cycle();
    end

    // Reset with three loads pending; late return afterwards.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      begin_cycle(); ld_issue = 1; ld_issue_dest = 4'(k); settle(); end_cycle();
    end
    do_reset();
    begin_cycle(); id_use1 = 1; id_src1 = 4'd1; id_use2 = 1; id_src2 = 4'd3; settle();
    chk("post rst stall", hazard_stall, 0); chk("post rst err", err, 0); end_cycle();
    begin_cycle(); ld_valid = 1; ld_data = 32'h5; settle(); end_cycle();
    begin_cycle(); settle(); chk("late ld err", err, 1); end_cycle();
    do_reset();

    // Random traffic; held returns keep their data until accepted.
    for (int c = 0; c < 3000; c++) begin
      logic keep;
      keep = hold;
      begin_cycle();
      wb_en = ($urandom_range(0, 99) < 40);
      wb_dest = 4'($urandom_range(0, 15)); wb_value = $urandom;
      ld_issue = ($urandom_range(0, 99) < 35);
      ld_issue_dest = 4'($urandom_range(0, 7));
      if (keep) ld_valid = 1;
      else begin
        ld_valid = (tagq.size() > 0) && ($urandom_range(0, 99) < 50);
        ld_data = $urandom;
      end
      id_src1 = 4'($urandom_range(0, 7)); id_use1 = $urandom_range(0, 1) == 1;
      id_src2 = 4'($urandom_range(0, 7)); id_use2 = $urandom_range(0, 1) == 1;
      id_dest = 4'($urandom_range(0, 7)); id_wb = $urandom_range(0, 1) == 1;
      settle();
      end_cycle();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
